// File: rtl/sha256_feeder.sv
// rtl/sha256_feeder.sv - Buffers message words, applies SHA-256 padding and chains blocks through an external compression core
module sha256_feeder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_data,
    input  logic         msg_last,
    input  logic [1:0]   msg_nbytes,
    output logic [511:0] core_data,
    output logic [255:0] core_vin,
    input  logic [255:0] core_hash,
    input  logic         core_valid,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {FILL, LOAD, FINISH, DONE} state_t;
    state_t state, state_nx;

    logic [31:0] blk_q [16];
    logic [31:0] h_q [8];
    logic [4:0]  widx;
    logic [31:0] byte_cnt;
    logic        in_flight, pad2, final_blk;

    logic        accept, load, capture, build_pad, release_h;
    logic [4:0]  pos;
    logic [2:0]  add_n;
    logic [31:0] byte_nx, len_src, last_word;

    always_comb begin
        state_nx  = state;
        msg_ready = 1'b0;
        load      = 1'b0;
        build_pad = 1'b0;
        capture   = core_valid && in_flight;
        case (state)
            FILL: begin
                if (pad2) begin
                    build_pad = 1'b1;
                    state_nx  = LOAD;
                end else begin
                    msg_ready = (widx < 5'd16);
                    if (msg_valid && msg_ready && (msg_last || widx == 5'd15))
                        state_nx = LOAD;
                end
            end
            // A pending result must be absorbed before the next block can use H as its chaining value.
            LOAD: begin
                if (core_valid && !in_flight) begin
                    load     = 1'b1;
                    state_nx = final_blk ? FINISH : FILL;
                end
            end
            FINISH:  if (capture) state_nx = DONE;
            DONE:    if (digest_ready) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    assign accept       = msg_valid && msg_ready;
    assign release_h    = (state == DONE) && digest_ready;
    assign digest_valid = (state == DONE);

    assign pos     = (msg_nbytes == 2'd0) ? widx + 5'd1 : widx;
    assign add_n   = (msg_last && msg_nbytes != 2'd0) ? {1'b0, msg_nbytes} : 3'd4;
    assign byte_nx = byte_cnt + {29'd0, add_n};
    assign len_src = build_pad ? byte_cnt : byte_nx;

    always_comb begin
        case (msg_nbytes)
            2'd1:    last_word = {msg_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {msg_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {msg_data[31:8], 8'h80};
            default: last_word = msg_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            widx      <= 5'd0;
            byte_cnt  <= 32'd0;
            in_flight <= 1'b0;
            pad2      <= 1'b0;
            final_blk <= 1'b0;
            for (int i = 0; i < 16; i++) blk_q[i] <= 32'd0;
            for (int i = 0; i < 8; i++) h_q[i] <= IV[255-32*i -: 32];
        end else begin
            state <= state_nx;
            if (capture) begin
                for (int i = 0; i < 8; i++) h_q[i] <= core_hash[255-32*i -: 32];
                in_flight <= 1'b0;
            end
            if (load) begin
                in_flight <= 1'b1;
                widx      <= 5'd0;
            end
            if (release_h) begin
                for (int i = 0; i < 8; i++) h_q[i] <= IV[255-32*i -: 32];
                byte_cnt <= 32'd0;
            end
            // Second padding block: the 0x80 marker lands in word 0 only when the message filled its last block exactly.
            if (build_pad) begin
                for (int i = 0; i < 14; i++) blk_q[i] <= 32'd0;
                if (byte_cnt[5:0] == 6'd0) blk_q[0] <= 32'h8000_0000;
                blk_q[14] <= {29'd0, len_src[31:29]};
                blk_q[15] <= {len_src[28:0], 3'b000};
                pad2      <= 1'b0;
                final_blk <= 1'b1;
            end
            if (accept) begin
                byte_cnt <= byte_nx;
                widx     <= widx + 5'd1;
                if (!msg_last) begin
                    blk_q[widx[3:0]] <= msg_data;
                    if (widx == 5'd15) final_blk <= 1'b0;
                end else begin
                    for (int j = 0; j < 16; j++) begin
                        if (5'(j) == widx)
                            blk_q[j] <= last_word;
                        else if (5'(j) > widx)
                            blk_q[j] <= (5'(j) == pos && msg_nbytes == 2'd0) ? 32'h8000_0000 : 32'd0;
                    end
                    if (pos <= 5'd13) begin
                        blk_q[14] <= {29'd0, len_src[31:29]};
                        blk_q[15] <= {len_src[28:0], 3'b000};
                        final_blk <= 1'b1;
                    end else begin
                        final_blk <= 1'b0;
                        pad2      <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_data
        assign core_data[32*i +: 32] = {blk_q[i][7:0], blk_q[i][15:8], blk_q[i][23:16], blk_q[i][31:24]};
    end

    for (genvar i = 0; i < 8; i++) begin : g_hash
        assign core_vin[32*i +: 32]    = h_q[i];
        assign digest[255-32*i -: 32]  = h_q[i];
    end

endmodule

// File: tb/tb_sha256_feeder.sv
// tb/tb_sha256_feeder.sv - Self-checking bench for sha256_feeder with a pipelined core model and a byte-level SHA-256 reference
module tb_sha256_feeder;

    localparam logic [255:0] IV         = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] Q56_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [31:0]  msg_data = 32'd0;
    logic         msg_last = 1'b0;
    logic [1:0]   msg_nbytes = 2'd0;
    logic [511:0] core_data;
    logic [255:0] core_vin;
    logic [255:0] core_hash = 256'd0;
    logic         core_valid = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned phase = 0;
    logic [255:0] iv_vin;

    sha256_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_last(msg_last), .msg_nbytes(msg_nbytes),
        .core_data(core_data), .core_vin(core_vin), .core_hash(core_hash), .core_valid(core_valid),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // hv: H0 in [255:224]; blk: W0 in [511:480]; returns the chained (feed-forward) hash.
    function automatic logic [255:0] sha_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, h} = hv;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hv[255:224], b + hv[223:192], c + hv[191:160], d + hv[159:128],
                e + hv[127:96],  f + hv[95:64],   g + hv[63:32],   h + hv[31:0]};
    endfunction

    function automatic logic [255:0] sha_ref(input logic [7:0] msg [$]);
        logic [7:0]   p [$];
        logic [63:0]  bitlen;
        logic [255:0] hv;
        logic [511:0] blk;
        p = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        hv = IV;
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bk + j];
            hv = sha_compress(hv, blk);
        end
        return hv;
    endfunction

    function automatic logic [255:0] vin_to_hv(input logic [255:0] v);
        logic [255:0] hv;
        for (int i = 0; i < 8; i++) hv[255-32*i -: 32] = v[32*i +: 32];
        return hv;
    endfunction

    function automatic logic [511:0] data_to_blk(input logic [511:0] d);
        logic [511:0] blk;
        logic [31:0]  w;
        for (int i = 0; i < 16; i++) begin
            w = d[32*i +: 32];
            blk[511-32*i -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return blk;
    endfunction

    // Core model: one pulse every 64 cycles; the result of the block taken at one pulse is presented at the next.
    always @(negedge clk) begin
        if (core_valid) core_hash = sha_compress(vin_to_hv(core_vin), data_to_blk(core_data));
        core_valid = ((cyc % 64) == phase);
        cyc++;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int t;
        msg_data = d; msg_last = last; msg_nbytes = nb; msg_valid = 1'b1;
        t = 0;
        while (msg_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        check("msg_accept_timeout", t < 2000, 1'b1);
        @(negedge clk);
        msg_valid = 1'b0; msg_last = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m [$], input int max_gap);
        int nw, rem;
        logic [31:0] d;
        nw = (m.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = $urandom;
            rem = m.size() - 4*w;
            for (int b = 0; b < 4; b++) if (b < rem) d[31-8*b -: 8] = m[4*w + b];
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            if (w == nw - 1) send_word(d, 1'b1, 2'(rem));
            else             send_word(d, 1'b0, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic wait_digest();
        int t;
        t = 0;
        while (digest_valid !== 1'b1 && t < 1500) begin @(negedge clk); t++; end
        check("digest_timeout", t < 1500, 1'b1);
    endtask

    task automatic ack(input int delay);
        repeat (delay) @(negedge clk);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        check("ack_dvalid", digest_valid, 1'b0);
        check("ack_ready", msg_ready, 1'b1);
        check("ack_iv", digest, IV);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, msg_ready, 1'b1);
        check({tag, "_dvalid"}, digest_valid, 1'b0);
        check({tag, "_digest"}, digest, IV);
        check({tag, "_vin"}, core_vin, iv_vin);
        check({tag, "_data"}, core_data, 512'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]   m [$];
        logic [255:0] exp;
        string        s;
        int           t;
        int           lens [16] = '{1, 3, 4, 52, 55, 56, 57, 59, 60, 63, 64, 65, 119, 120, 128, 200};

        phase = $urandom_range(0, 63);
        for (int i = 0; i < 8; i++) iv_vin[32*i +: 32] = IV[255-32*i -: 32];
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        check("abc_word0", core_data[31:0], 32'h80636261);
        check("abc_len", core_data[511:480], 32'h18000000);
        wait_digest();
        check("abc_digest", digest, ABC_DIGEST);
        ack(2);

        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m.delete();
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        send_msg(m, 2);
        check("q56_word14", core_data[479:448], 32'h00000080);
        check("q56_word15", core_data[511:480], 32'h00000000);
        wait_digest();
        check("q56_digest", digest, Q56_DIGEST);
        check("q56_pad_word0", core_data[31:0], 32'h00000000);
        check("q56_pad_len", core_data[511:480], 32'hc0010000);
        ack(1);

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        exp = sha_ref(m);
        send_msg(m, 1);
        wait_digest();
        check("m64_digest", digest, exp);
        check("m64_pad_word0", core_data[31:0], 32'h00000080);
        check("m64_pad_len", core_data[511:480], 32'h00020000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("hold_dvalid", digest_valid, 1'b1);
            check("hold_digest", digest, exp);
            check("hold_ready", msg_ready, 1'b0);
        end
        ack(0);

        // Reset while a full block waits in LOAD behind one still in the core.
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0, 2'd0);
        t = 0;
        while (msg_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("first_load_timeout", t < 200, 1'b1);
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0, 2'd0);
        check("load_ready_low", msg_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        wait_digest();
        check("abc_after_rst", digest, ABC_DIGEST);
        ack(3);

        for (int k = 0; k < 24; k++) begin
            int len;
            len = (k < 16) ? lens[k] : int'($urandom_range(1, 200));
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            exp = sha_ref(m);
            send_msg(m, 3);
            wait_digest();
            check($sformatf("rand_len%0d", len), digest, exp);
            ack($urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
